// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronises two external pins, generates periodic timer ticks,
// and presents one masked, prioritised request at a time, blocking nesting until reti.
module intr_ctrl #(
  parameter int                  PC_WIDTH    = 10,
  parameter int                  TIMER_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] VEC_INTR1   = 10'h3F0,
  parameter logic [PC_WIDTH-1:0] VEC_INTR2   = 10'h3F4,
  parameter logic [PC_WIDTH-1:0] VEC_TIMER   = 10'h3F8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   intr1,
  input  logic                   intr2,
  input  logic                   timer_e,
  input  logic [TIMER_WIDTH-1:0] timer_period,
  input  logic                   mask_we,
  input  logic [2:0]             mask_in,
  input  logic                   int_ack,
  input  logic                   reti,
  output logic                   int_req,
  output logic [PC_WIDTH-1:0]    int_vector,
  output logic [1:0]             int_id,
  output logic [2:0]             pending,
  output logic                   in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] T_ZERO = {TIMER_WIDTH{1'b0}};
  localparam logic [TIMER_WIDTH-1:0] T_ONE  = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic [1:0]              sync1_r, sync2_r, sync3_r;
  logic [1:0]              edge_s;
  logic [TIMER_WIDTH-1:0]  tcnt_r;
  logic                    tick_s;
  logic [2:0]              pending_r, mask_r, active_s, set_s, clr_s;
  logic [1:0]              win_id_s;
  logic [PC_WIDTH-1:0]     win_vec_s;
  logic                    int_req_r, in_service_r;
  logic [1:0]              int_id_r;
  logic [PC_WIDTH-1:0]     int_vector_r;

  // bit0 = intr1, bit1 = intr2; sync3 is the history flop for edge detection
  assign edge_s   = sync2_r & ~sync3_r;
  assign active_s = pending_r & mask_r;
  assign set_s    = {tick_s, edge_s};

  // Pin synchronisers and history
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      sync3_r <= 2'b00;
    end else begin
      sync1_r <= {intr2, intr1};
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Timer compare: a new period is only seen here, so a counter past it runs on to wrap
  always_comb begin
    tick_s = 1'b0;
    if (timer_e && (timer_period != T_ZERO) && (tcnt_r == (timer_period - T_ONE))) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Timer counter
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_r <= T_ZERO;
    end else if (!timer_e || (timer_period == T_ZERO) || tick_s) begin
      tcnt_r <= T_ZERO;
    end else begin
      tcnt_r <= tcnt_r + T_ONE;
    end
  end

  // Fixed priority winner over enabled pending sources
  always_comb begin
    win_id_s  = 2'd0;
    win_vec_s = {PC_WIDTH{1'b0}};
    if (active_s[0]) begin
      win_id_s  = 2'd1;
      win_vec_s = VEC_INTR1;
    end else if (active_s[1]) begin
      win_id_s  = 2'd2;
      win_vec_s = VEC_INTR2;
    end else if (active_s[2]) begin
      win_id_s  = 2'd3;
      win_vec_s = VEC_TIMER;
    end else begin
      win_id_s  = 2'd0;
      win_vec_s = {PC_WIDTH{1'b0}};
    end
  end

  // Pending bit cleared by an accepted acknowledge of its own id
  always_comb begin
    clr_s = 3'b000;
    if ((state_r == REQ) && int_ack) begin
      case (int_id_r)
        2'd1:    clr_s = 3'b001;
        2'd2:    clr_s = 3'b010;
        2'd3:    clr_s = 3'b100;
        default: clr_s = 3'b000;
      endcase
    end else begin
      clr_s = 3'b000;
    end
  end

  // Pending and mask registers; a simultaneous set beats the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= 3'b000;
      mask_r    <= 3'b000;
    end else begin
      pending_r <= (pending_r & ~clr_s) | set_s;
      if (mask_we) begin
        mask_r <= mask_in;
      end
    end
  end

  // Request/service FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      int_req_r    <= 1'b0;
      int_id_r     <= 2'd0;
      int_vector_r <= {PC_WIDTH{1'b0}};
      in_service_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (active_s != 3'b000) begin
            state_r      <= REQ;
            int_req_r    <= 1'b1;
            int_id_r     <= win_id_s;
            int_vector_r <= win_vec_s;
          end
        end
        REQ: begin
          if (int_ack) begin
            state_r      <= SERVICE;
            int_req_r    <= 1'b0;
            in_service_r <= 1'b1;
          end
        end
        SERVICE: begin
          if (reti) begin
            state_r      <= IDLE;
            int_id_r     <= 2'd0;
            int_vector_r <= {PC_WIDTH{1'b0}};
            in_service_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          int_req_r    <= 1'b0;
          int_id_r     <= 2'd0;
          int_vector_r <= {PC_WIDTH{1'b0}};
          in_service_r <= 1'b0;
        end
      endcase
    end
  end

  assign int_req    = int_req_r;
  assign int_id     = int_id_r;
  assign int_vector = int_vector_r;
  assign pending    = pending_r;
  assign in_service = in_service_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios plus randomized traffic, every cycle compared
// against a behavioural model built from sample histories and a request/service mode.
module tb_intr_ctrl;

  localparam logic [9:0] V1 = 10'h3F0;
  localparam logic [9:0] V2 = 10'h3F4;
  localparam logic [9:0] VT = 10'h3F8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        intr1 = 1'b0, intr2 = 1'b0;
  logic        timer_e = 1'b0;
  logic [15:0] timer_period = 16'd0;
  logic        mask_we = 1'b0;
  logic [2:0]  mask_in = 3'b000;
  logic        int_ack = 1'b0, reti = 1'b0;
  logic        int_req;
  logic [9:0]  int_vector;
  logic [1:0]  int_id;
  logic [2:0]  pending;
  logic        in_service;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          h1 [3];
  bit          h2 [3];
  int          m_tcnt;
  int          m_mode;            // 0 idle, 1 requesting, 2 in service
  logic [2:0]  m_pend, m_mask;
  logic        m_req, m_svc;
  logic [1:0]  m_id;
  logic [9:0]  m_vec;

  intr_ctrl dut (
    .clk(clk), .reset(reset), .intr1(intr1), .intr2(intr2),
    .timer_e(timer_e), .timer_period(timer_period),
    .mask_we(mask_we), .mask_in(mask_in), .int_ack(int_ack), .reti(reti),
    .int_req(int_req), .int_vector(int_vector), .int_id(int_id),
    .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // one clock edge of the model, using the inputs as seen at that edge
  task automatic model_edge();
    bit ev1, ev2, tick;
    logic [2:0] clr;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin h1[i] = 1'b0; h2[i] = 1'b0; end
      m_tcnt = 0; m_mode = 0; m_pend = 3'b000; m_mask = 3'b000;
      m_req = 1'b0; m_svc = 1'b0; m_id = 2'd0; m_vec = 10'd0;
    end else begin
      ev1 = h1[1] && !h1[2];
      ev2 = h2[1] && !h2[2];
      h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = intr1;
      h2[2] = h2[1]; h2[1] = h2[0]; h2[0] = intr2;
      tick = 1'b0;
      if (timer_e && timer_period != 16'd0) begin
        if (m_tcnt == int'(timer_period) - 1) begin
          tick = 1'b1; m_tcnt = 0;
        end else begin
          m_tcnt = (m_tcnt + 1) % 65536;
        end
      end else begin
        m_tcnt = 0;
      end
      clr = 3'b000;
      if (m_mode == 0) begin
        for (int b = 0; b < 3; b++) begin
          if (m_mode == 0 && m_pend[b] && m_mask[b]) begin
            m_mode = 1; m_req = 1'b1; m_id = 2'(b + 1);
            m_vec = (b == 0) ? V1 : (b == 1) ? V2 : VT;
          end
        end
      end else if (m_mode == 1) begin
        if (int_ack) begin
          clr[m_id - 2'd1] = 1'b1;
          m_mode = 2; m_req = 1'b0; m_svc = 1'b1;
        end
      end else if (reti) begin
        m_mode = 0; m_svc = 1'b0; m_id = 2'd0; m_vec = 10'd0;
      end
      m_pend = (m_pend & ~clr) | {tick, ev2, ev1};
      if (mask_we) m_mask = mask_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("int_req", int_req, m_req);
    chk("int_id", int_id, m_id);
    chk("int_vector", int_vector, m_vec);
    chk("pending", pending, m_pend);
    chk("in_service", in_service, m_svc);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // reset, enable all, intr1 rises at edge 0
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_req", int_req, 1'b0);
    chk("rst_pend", pending, 3'b000);
    mask_we = 1'b1; mask_in = 3'b111; step(); mask_we = 1'b0;
    intr1 = 1'b1; steps(2);
    chk("pin_lat_early", pending, 3'b000);
    step();
    chk("pin_lat_pend", pending, 3'b001);
    step();
    chk("req_up", int_req, 1'b1);
    chk("req_id1", int_id, 2'd1);
    chk("req_vec1", int_vector, V1);
    intr1 = 1'b0; int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("ack_svc", in_service, 1'b1);
    chk("ack_clr", pending, 3'b000);
    reti = 1'b1; step(); reti = 1'b0;
    chk("reti_id0", int_id, 2'd0);

    // both pins together: intr1 wins, then intr2 after reti
    intr1 = 1'b1; intr2 = 1'b1; steps(4);
    chk("both_id1", int_id, 2'd1);
    int_ack = 1'b1; reti = 1'b1; step(); int_ack = 1'b0; reti = 1'b0;
    chk("both_pend", pending, 3'b010);
    chk("ack_wins_reti", in_service, 1'b1);
    reti = 1'b1; step(); reti = 1'b0; step();
    chk("next_id2", int_id, 2'd2);
    chk("next_vec2", int_vector, V2);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    reti = 1'b1; step(); reti = 1'b0;
    intr1 = 1'b0; intr2 = 1'b0;

    // timer only, period 4
    mask_we = 1'b1; mask_in = 3'b100; timer_period = 16'd4; timer_e = 1'b1;
    step(); mask_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int_ack = (m_mode == 1);
      reti = (m_mode == 2);
      step();
      if (m_req) chk("tmr_id", int_id, 2'd3);
      if (m_req) chk("tmr_vec", int_vector, VT);
    end
    int_ack = 1'b0; reti = 1'b0; timer_e = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;

    // masked intr2 stays pending, request follows a mask write
    intr2 = 1'b1; steps(2); intr2 = 1'b0; steps(4);
    chk("masked_pend", pending, 3'b010);
    chk("masked_noreq", int_req, 1'b0);
    mask_we = 1'b1; mask_in = 3'b010; step(); mask_we = 1'b0;
    chk("mask_wr_1", int_req, 1'b0);
    step();
    chk("mask_wr_2", int_req, 1'b1);
    chk("mask_wr_id", int_id, 2'd2);

    // intr1 held during service of intr2: one event, no request until reti
    mask_we = 1'b1; mask_in = 3'b011; int_ack = 1'b1; step();
    mask_we = 1'b0; int_ack = 1'b0;
    intr1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("svc_noreq", int_req, 1'b0);
    end
    chk("svc_pend1", pending, 3'b001);
    reti = 1'b1; step(); reti = 1'b0; step();
    chk("post_reti_id1", int_id, 2'd1);
    int_ack = 1'b1; step(); int_ack = 1'b0; steps(4);
    chk("held_one_event", pending, 3'b000);
    intr1 = 1'b0; reti = 1'b1; step(); reti = 1'b0;

    // reset while requesting, then ack in idle
    intr2 = 1'b1; steps(4);
    chk("pre_rst_req", int_req, 1'b1);
    reset = 1'b1; step(); reset = 1'b0; intr2 = 1'b0;
    chk("rst_in_req", int_req, 1'b0);
    chk("rst_pend0", pending, 3'b000);
    intr1 = 1'b1; steps(5);
    chk("rst_mask0", int_req, 1'b0);
    int_ack = 1'b1; step(); int_ack = 1'b0; intr1 = 1'b0;
    chk("idle_ack_pend", pending, 3'b001);
    chk("idle_ack_svc", in_service, 1'b0);

    // randomized traffic
    reset = 1'b1; step(); reset = 1'b0;
    timer_e = 1'b1; timer_period = 16'd6;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) intr1 = ~intr1;
      if ($urandom_range(0, 7) == 0) intr2 = ~intr2;
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) timer_period = 16'($urandom_range(0, 9));
      if ($urandom_range(0, 49) == 0) timer_e = ~timer_e;
      int_ack = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      reti = (m_mode == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
